// File: rtl/pc_fetch_ctrl.sv
// PC and fetch control: drives the instruction-memory request, hands fetched PCs to IF/ID,
// and redirects/flushes on taken branches and jumps resolved in EX (static not-taken).
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_is_jump,
   input  logic        ex_branch_cond,
   input  logic [31:0] ex_target,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        trap_misalign,
   output logic [31:0] redirect_cnt
);

   localparam logic [1:0] ST_BOOT   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_FROZEN = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] redirect_cnt_q, redirect_cnt_d;

   logic taken, redirect, misalign, accept;

   // A jump overrides the branch condition when both type bits are set.
   assign taken    = ex_valid & (ex_is_jump | (ex_is_branch & ex_branch_cond));
   assign redirect = taken & ~rst & (state_q != ST_BOOT);
   assign misalign = redirect & (ex_target[1:0] != 2'b00);
   assign accept   = imem_req_valid & imem_req_ready;

   assign imem_req_valid = (state_q == ST_RUN);
   assign imem_req_addr  = pc_q;
   assign if_valid       = if_valid_q;
   assign if_pc          = if_pc_q;
   assign flush_if_id    = redirect;
   assign flush_id_ex    = redirect;
   assign trap_misalign  = misalign;
   assign redirect_cnt   = redirect_cnt_q;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      if_pc_d        = if_pc_q;
      if_valid_d     = if_valid_q;
      redirect_cnt_d = redirect_cnt_q;
      if (state_q == ST_BOOT) begin
         state_d = ST_RUN;
      end else if (redirect) begin
         // Any same-cycle accept is squashed: its pc+4 and IF/ID update are dropped.
         state_d    = ST_RUN;
         if_valid_d = 1'b0;
         if (misalign) begin
            pc_d = TRAP_VEC;
         end else begin
            pc_d           = ex_target;
            redirect_cnt_d = redirect_cnt_q + 32'd1;
         end
      end else if (stall) begin
         state_d = ST_FROZEN;
      end else if (state_q == ST_RUN) begin
         if (accept) begin
            pc_d       = pc_q + 32'd4;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
         end else begin
            if_valid_d = 1'b0;
         end
      end else begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_BOOT;
         pc_q           <= RESET_PC;
         if_pc_q        <= 32'd0;
         if_valid_q     <= 1'b0;
         redirect_cnt_q <= 32'd0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         if_pc_q        <= if_pc_d;
         if_valid_q     <= if_valid_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed vectors for pc_fetch_ctrl: the driver pushes hand-computed per-cycle expectations,
// and a monitor on the falling edge pops and compares them against the DUT outputs.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, stall, ex_valid, ex_is_branch, ex_is_jump, ex_branch_cond;
   logic [31:0] ex_target;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        if_valid, flush_if_id, flush_id_ex, trap_misalign;
   logic [31:0] if_pc, redirect_cnt;

   typedef struct {
      logic        rv;
      logic [31:0] addr;
      logic        ifv;
      logic [31:0] ifpc;
      logic        fl;
      logic        trap;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_no = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk(clk), .rst(rst), .stall(stall),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
      .ex_branch_cond(ex_branch_cond), .ex_target(ex_target),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .if_valid(if_valid), .if_pc(if_pc),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .trap_misalign(trap_misalign), .redirect_cnt(redirect_cnt)
   );

   task automatic chk(input string name, input int v, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL vec%0d %s: got %h want %h", v, name, act, req);
      end
   endtask

   // Monitor: every falling edge with an outstanding expectation is compared.
   int mon_no = 0;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         mon_no++;
         chk("req_valid", mon_no, {31'd0, imem_req_valid}, {31'd0, e.rv});
         chk("req_addr",  mon_no, imem_req_addr, e.addr);
         chk("if_valid",  mon_no, {31'd0, if_valid}, {31'd0, e.ifv});
         chk("if_pc",     mon_no, if_pc, e.ifpc);
         chk("flush_if_id", mon_no, {31'd0, flush_if_id}, {31'd0, e.fl});
         chk("flush_id_ex", mon_no, {31'd0, flush_id_ex}, {31'd0, e.fl});
         chk("trap",      mon_no, {31'd0, trap_misalign}, {31'd0, e.trap});
         chk("cnt",       mon_no, redirect_cnt, e.cnt);
      end
   end

   // One clock cycle: inputs {rst,stall,ready,exv,br,jp,cond}, target, then expected outputs.
   task automatic step(input logic [6:0] in, input logic [31:0] tgt,
                       input logic rv, input logic [31:0] addr, input logic ifv,
                       input logic [31:0] ifpc, input logic fl, input logic trap,
                       input logic [31:0] cnt, input logic frc);
      exp_t e;
      @(posedge clk);
      #1;
      {rst, stall, imem_req_ready, ex_valid, ex_is_branch, ex_is_jump, ex_branch_cond} = in;
      ex_target = tgt;
      if (frc) begin
         force dut.redirect_cnt_q = 32'hFFFF_FFFF;
         #1 release dut.redirect_cnt_q;
      end
      e.rv = rv; e.addr = addr; e.ifv = ifv; e.ifpc = ifpc;
      e.fl = fl; e.trap = trap; e.cnt = cnt;
      exp_q.push_back(e);
      vec_no++;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; imem_req_ready = 1'b0;
      ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_branch_cond = 1'b0;
      ex_target = 32'd0;
      @(posedge clk);
      //        rst st rdy exv br jp cd  target        rv addr          ifv ifpc          fl tr cnt           frc
      // reset held with a jump on EX: flushes stay low
      step(7'b1_0_0_1_0_1_0, 32'h0000_0080, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 32'd0, 0);
      // BOOT: jump on EX ignored
      step(7'b0_0_1_1_0_1_0, 32'h0000_0080, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 32'd0, 0);
      step(7'b0_0_1_0_0_0_0, 32'h0,        1, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 32'd0, 0);
      step(7'b0_0_1_0_0_0_0, 32'h0,        1, 32'h0000_0004, 1, 32'h0000_0000, 0, 0, 32'd0, 0);
      step(7'b0_0_1_0_0_0_0, 32'h0,        1, 32'h0000_0008, 1, 32'h0000_0004, 0, 0, 32'd0, 0);
      step(7'b0_0_1_0_0_0_0, 32'h0,        1, 32'h0000_000C, 1, 32'h0000_0008, 0, 0, 32'd0, 0);
      // ready low three cycles at 0x10
      step(7'b0_0_0_0_0_0_0, 32'h0,        1, 32'h0000_0010, 1, 32'h0000_000C, 0, 0, 32'd0, 0);
      step(7'b0_0_0_0_0_0_0, 32'h0,        1, 32'h0000_0010, 0, 32'h0000_000C, 0, 0, 32'd0, 0);
      step(7'b0_0_0_0_0_0_0, 32'h0,        1, 32'h0000_0010, 0, 32'h0000_000C, 0, 0, 32'd0, 0);
      step(7'b0_0_1_0_0_0_0, 32'h0,        1, 32'h0000_0010, 0, 32'h0000_000C, 0, 0, 32'd0, 0);
      // stall two cycles
      step(7'b0_1_1_0_0_0_0, 32'h0,        1, 32'h0000_0014, 1, 32'h0000_0010, 0, 0, 32'd0, 0);
      step(7'b0_1_1_0_0_0_0, 32'h0,        0, 32'h0000_0014, 1, 32'h0000_0010, 0, 0, 32'd0, 0);
      step(7'b0_0_1_0_0_0_0, 32'h0,        0, 32'h0000_0014, 1, 32'h0000_0010, 0, 0, 32'd0, 0);
      step(7'b0_0_1_0_0_0_0, 32'h0,        1, 32'h0000_0014, 1, 32'h0000_0010, 0, 0, 32'd0, 0);
      // taken branch to 0x40
      step(7'b0_0_1_1_1_0_1, 32'h0000_0040, 1, 32'h0000_0018, 1, 32'h0000_0014, 1, 0, 32'd0, 0);
      step(7'b0_0_1_0_0_0_0, 32'h0,        1, 32'h0000_0040, 0, 32'h0000_0014, 0, 0, 32'd1, 0);
      // taken jump while stalled
      step(7'b0_1_1_1_0_1_0, 32'h0000_0080, 1, 32'h0000_0044, 1, 32'h0000_0040, 1, 0, 32'd1, 0);
      // taken branch coinciding with an accept
      step(7'b0_0_1_1_1_0_1, 32'h0000_0200, 1, 32'h0000_0080, 0, 32'h0000_0040, 1, 0, 32'd2, 0);
      // misaligned jump target
      step(7'b0_0_1_1_0_1_0, 32'h0000_0042, 1, 32'h0000_0200, 0, 32'h0000_0040, 1, 1, 32'd3, 0);
      // not-taken branch
      step(7'b0_0_1_1_1_0_0, 32'h0000_0300, 1, 32'h0000_0100, 0, 32'h0000_0040, 0, 0, 32'd3, 0);
      // branch+jump bits with cond=0: treated as jump
      step(7'b0_0_1_1_1_1_0, 32'h0000_0500, 1, 32'h0000_0104, 1, 32'h0000_0100, 1, 0, 32'd3, 0);
      // jump bit without ex_valid
      step(7'b0_0_1_0_0_1_0, 32'h0000_0700, 1, 32'h0000_0500, 0, 32'h0000_0100, 0, 0, 32'd4, 0);
      // counter preloaded to all-ones, then a taken jump wraps it
      step(7'b0_0_1_1_0_1_0, 32'h0000_0600, 1, 32'h0000_0504, 1, 32'h0000_0500, 1, 0, 32'hFFFF_FFFF, 1);
      // rst during a redirect
      step(7'b1_0_1_1_0_1_0, 32'h0000_0700, 1, 32'h0000_0600, 0, 32'h0000_0500, 0, 0, 32'd0, 0);
      step(7'b0_0_1_0_0_0_0, 32'h0,        0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 32'd0, 0);
      step(7'b0_0_1_0_0_0_0, 32'h0,        1, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 32'd0, 0);
      step(7'b0_0_1_0_0_0_0, 32'h0,        1, 32'h0000_0004, 1, 32'h0000_0000, 0, 0, 32'd0, 0);
      begin
         int guard = 0;
         while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
         end
         if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
         end
      end
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-control stage of the RISC-V core. It consumes the branch-taken decision produced by the execute-stage branch comparator, redirects the PC, and issues flushes. It also drives the instruction-memory request handshake and hands the fetched PC to IF/ID. Prediction is static not-taken, so every taken branch or jump costs a two-stage flush.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- TRAP_VEC, 32'h0000_0100: redirect address on a misaligned control-transfer target.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  reset, synchronous and active-high (one clock; polarity and synchronicity fixed).
- stall  in  1  hazard-unit freeze of fetch.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_is_jump  in  1  EX instruction is JAL/JALR.
- ex_branch_cond  in  1  branch comparator result (1 = condition true).
- ex_target  in  32  computed branch/jump target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address (current PC).
- imem_req_ready  in  1  memory accepts request.
- if_valid  out  1  IF/ID slot holds a live fetched PC.
- if_pc  out  32  PC of the instruction in IF/ID.
- flush_if_id  out  1  kill IF/ID contents.
- flush_id_ex  out  1  kill ID/EX contents.
- trap_misalign  out  1  one-cycle pulse: taken target not word-aligned.
- redirect_cnt  out  32  count of taken redirects.

## Operation
- Taken = ex_valid & (ex_is_jump | (ex_is_branch & ex_branch_cond)); if both type bits are high, treat as jump.
- States:
  - BOOT: one cycle after rst; imem_req_valid=0; goes to RUN.
  - RUN: normal fetch.
  - FROZEN: entered while stall=1 and no taken; exits to RUN the cycle stall falls.
- RUN:
  - imem_req_valid=1 and imem_req_addr=pc.
  - Accept = valid & ready. On accept: pc <= pc+4 (mod 2^32), if_pc <= pc, if_valid <= 1.
  - No accept: pc and imem_req_addr held stable; if_valid <= 0.
- FROZEN: imem_req_valid=0; pc, if_pc and if_valid held.
- Taken (any state except BOOT):
  - flush_if_id=1 and flush_id_ex=1 combinationally in the same cycle.
  - Next edge: pc <= ex_target, if_valid <= 0, state <= RUN.
  - redirect_cnt increments, wrapping 0xFFFF_FFFF -> 0.
  - A request accepted in that same cycle is squashed: pc+4 is discarded and if_valid is 0.
- Misaligned: taken with ex_target[1:0] != 2'b00.
  - pc <= TRAP_VEC instead of ex_target.
  - trap_misalign=1 for that cycle only.
  - Flushes asserted; redirect_cnt does not increment.
- Priority, highest first: rst > taken > stall > accept.

## Timing
- Reset values:
  - pc=RESET_PC, state=BOOT.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - if_valid=0, if_pc=0, flush_if_id=0, flush_id_ex=0, trap_misalign=0, redirect_cnt=0.
- First request: cycle 1 after rst deasserts, addr=RESET_PC.
- Redirect latency: decision in cycle N; imem_req_addr=target in cycle N+1.
- Flushes and trap_misalign are combinational from EX inputs and valid only while rst=0; they are 0 during rst and in BOOT.
- imem_req_addr must not change while imem_req_valid=1 and ready=0, except on taken or rst.
- rst asserted mid-stream:
  - Next edge: full reset state.
  - Any outstanding request is abandoned.
  - redirect_cnt cleared.

## Test plan
- Reset then ready=1 for 4 cycles -> BOOT cycle with valid=0, then addrs 0x0, 0x4, 0x8, 0xC; if_pc lags addr by one cycle.
- Branch taken in cycle N (ex_branch_cond=1, ex_target=0x40) -> both flushes high in N; addr=0x40 in N+1; if_valid=0 in N+1; redirect_cnt=1.
- ready=0 for 3 cycles at pc=0x10, stall=1 for 2 cycles later -> addr held at 0x10; pc does not advance; FROZEN drops valid; fetch resumes at the same pc.
- Taken with stall=1, then taken with ready=1 in the same cycle as an accept -> redirect wins both times; pc+4 discarded; if_valid=0.
- Jump to ex_target=0x42 -> trap_misalign pulse one cycle; pc=TRAP_VEC (0x100); redirect_cnt unchanged. ex_is_branch=1 with cond=0 -> no flush, sequential fetch continues.
- redirect_cnt preloaded via force to 0xFFFF_FFFF, then one taken -> 0. rst mid-redirect -> next edge pc=RESET_PC, counter 0, BOOT.
